// File: rtl/mac_controller.sv
// Sequencing FSM for a dot-product MAC datapath: operand handshake, multiplier
// run with timeout, add/accumulate per pair, done/timeout reporting.
module mac_controller #(
  parameter int MUL_TIMEOUT = 32,
  parameter int LEN_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ldA,
  output logic             ldB,
  output logic             rst_for_mul,
  output logic             start_mul,
  input  logic             valid_mul,
  output logic             start_adder,
  output logic             ldacc,
  output logic             acc_clr,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int TW = (MUL_TIMEOUT > 2) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(MUL_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    WAIT_OP,
    MUL_RST,
    MUL_RUN,
    ADD,
    ACC,
    NEXT,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] remaining_reg, remaining_next;
  logic [TW-1:0]    tcnt_reg, tcnt_next;
  logic             timeout_reg, timeout_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      tcnt_reg      <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      tcnt_reg      <= tcnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    tcnt_next      = tcnt_reg;
    timeout_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          remaining_next = vec_len;
          state_next     = CLR;
        end
      end
      CLR:     state_next = (remaining_reg == '0) ? DONE : WAIT_OP;
      WAIT_OP: if (in_valid) state_next = MUL_RST;
      MUL_RST: begin
        tcnt_next  = '0;
        state_next = MUL_RUN;
      end
      MUL_RUN: begin
        // A product arriving on the final allowed cycle still wins over timeout.
        if (valid_mul) begin
          state_next = ADD;
        end else if (tcnt_reg == TCNT_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          tcnt_next = tcnt_reg + TW'(1);
        end
      end
      ADD: state_next = ACC;
      ACC: state_next = NEXT;
      NEXT: begin
        remaining_next = remaining_reg - LEN_W'(1);
        state_next     = (remaining_reg == LEN_W'(1)) ? DONE : WAIT_OP;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs follow in_valid combinationally so a pair can be taken
  // on the first WAIT_OP cycle; everything else is decoded from state alone.
  always_comb begin
    in_ready    = (state_reg == WAIT_OP);
    ldA         = in_ready && in_valid;
    ldB         = in_ready && in_valid;
    acc_clr     = (state_reg == CLR);
    rst_for_mul = (state_reg == MUL_RST);
    start_mul   = (state_reg == MUL_RUN);
    start_adder = (state_reg == ADD) || (state_reg == ACC);
    ldacc       = (state_reg == ACC);
    done        = (state_reg == DONE);
    busy        = (state_reg != IDLE);
    timeout_err = timeout_reg;
  end

endmodule

// File: tb/tb_mac_controller.sv
// Directed bench for mac_controller with a small behavioural MAC datapath
// (operand regs, fixed-latency multiplier, accumulator) hung off its controls.
module tb_mac_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] vec_len;
  logic       in_valid;
  logic       in_ready;
  logic       ldA, ldB;
  logic       rst_for_mul, start_mul, valid_mul;
  logic       start_adder, ldacc, acc_clr;
  logic       busy, done, timeout_err;
  logic [7:0] da, db;
  logic [10:0] outs;

  always #5 clk = ~clk;

  mac_controller #(.MUL_TIMEOUT(32), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready), .ldA(ldA), .ldB(ldB),
    .rst_for_mul(rst_for_mul), .start_mul(start_mul), .valid_mul(valid_mul),
    .start_adder(start_adder), .ldacc(ldacc), .acc_clr(acc_clr),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  assign outs = {in_ready, ldA, ldB, rst_for_mul, start_mul, start_adder,
                 ldacc, acc_clr, busy, done, timeout_err};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model; cur_lat = 0 means the multiplier never answers.
  int ra = 0, rb = 0, prod = 0, acc = 0, mcnt = 0, cur_lat = 1;
  assign valid_mul = start_mul && (cur_lat != 0) && (mcnt == cur_lat - 1);
  always @(posedge clk) begin
    if (ldA) ra <= int'(da);
    if (ldB) rb <= int'(db);
    if (rst_for_mul) mcnt <= 0;
    else if (start_mul) mcnt <= mcnt + 1;
    if (valid_mul) prod <= ra * rb;
    if (acc_clr) acc <= 0;
    else if (ldacc) acc <= acc + prod;
  end

  int n_done = 0, n_to = 0, n_ldacc = 0, n_smul = 0, n_clr = 0, n_lda = 0, n_ov = 0;
  always @(negedge clk) begin
    if (done) n_done <= n_done + 1;
    if (timeout_err) n_to <= n_to + 1;
    if (ldacc) n_ldacc <= n_ldacc + 1;
    if (start_mul) n_smul <= n_smul + 1;
    if (acc_clr) n_clr <= n_clr + 1;
    if (ldA) n_lda <= n_lda + 1;
    if ((ldacc && acc_clr) || (rst_for_mul && start_mul)) n_ov <= n_ov + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int len; int lat; int gap;
    logic [3:0][7:0] a; logic [3:0][7:0] b;
    int exp_sum; int exp_lda; int exp_smul; int exp_ldacc; int exp_done;
    int exp_to; int exp_lat; int exp_span; int exp_togap;
  } row_t;

  row_t rows[6];

  task automatic run_job(input int id, input row_t r);
    int b_done, b_to, b_ld, b_sm, b_lda, b_ov;
    int idx, gap_left, hs_t, ld_t, clr_t, done_t, to_t, sm_t;
    int lat_m, span_m, togap_m;
    bit fin;
    cur_lat = r.lat;
    b_done = n_done; b_to = n_to; b_ld = n_ldacc; b_sm = n_smul; b_lda = n_lda; b_ov = n_ov;
    hs_t = -1; ld_t = -1; clr_t = -1; done_t = -1; to_t = -1; sm_t = -1;
    vec_len = 4'(r.len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; vec_len = '0;
    idx = 0; gap_left = r.gap; fin = 1'b0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      if (idx < r.len && gap_left == 0) begin
        in_valid = 1'b1; da = r.a[idx % 4]; db = r.b[idx % 4];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_ready && in_valid) begin
        if (idx == 0) hs_t = cyc;
        idx++;
        gap_left = r.gap;
      end else if (in_ready && gap_left > 0) begin
        gap_left--;
      end
      if (ldacc && ld_t < 0) ld_t = cyc;
      if (acc_clr) clr_t = cyc;
      if (start_mul) sm_t = cyc;
      if (done) begin done_t = cyc; fin = 1'b1; end
      if (timeout_err) begin to_t = cyc; fin = 1'b1; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk($sformatf("row%0d finished", id), int'(fin), 1);
    chk($sformatf("row%0d busy_after", id), int'(busy), 0);
    @(posedge clk); #1;
    lat_m   = (hs_t >= 0 && ld_t >= 0) ? ld_t - hs_t : -1;
    span_m  = (done_t >= 0) ? done_t - clr_t : -1;
    togap_m = (to_t >= 0) ? to_t - sm_t : 0;
    chk($sformatf("row%0d sum", id), acc, r.exp_sum);
    chk($sformatf("row%0d ldA_cycles", id), n_lda - b_lda, r.exp_lda);
    chk($sformatf("row%0d start_mul_cycles", id), n_smul - b_sm, r.exp_smul);
    chk($sformatf("row%0d ldacc_pulses", id), n_ldacc - b_ld, r.exp_ldacc);
    chk($sformatf("row%0d done_pulses", id), n_done - b_done, r.exp_done);
    chk($sformatf("row%0d timeout_pulses", id), n_to - b_to, r.exp_to);
    chk($sformatf("row%0d pair_latency", id), lat_m, r.exp_lat);
    chk($sformatf("row%0d clr_to_done", id), span_m, r.exp_span);
    chk($sformatf("row%0d timeout_gap", id), togap_m, r.exp_togap);
    chk($sformatf("row%0d exclusive_outputs", id), n_ov - b_ov, 0);
  endtask

  initial begin
    int b_clr, b_done, b_to;
    bit found;
    //        len lat gap a(pair n in byte n)         b                          sum lda smul ldacc done to lat span togap
    rows[0] = '{3, 8, 0, {8'd0, 8'd1, 8'd4, 8'd2},  {8'd0, 8'd7, 8'd5, 8'd3},  33, 3, 24, 3, 1, 0, 11, 40, 0};
    rows[1] = '{0, 8, 0, {8'd0, 8'd0, 8'd0, 8'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   0, 0,  0, 0, 1, 0, -1,  1, 0};
    rows[2] = '{1, 1, 0, {8'd0, 8'd0, 8'd0, 8'd9},  {8'd0, 8'd0, 8'd0, 8'd9},  81, 1,  1, 1, 1, 0,  4,  7, 0};
    rows[3] = '{2, 3, 2, {8'd0, 8'd0, 8'd0, 8'd10}, {8'd0, 8'd0, 8'd5, 8'd10}, 100, 2, 6, 2, 1, 0,  6, 21, 0};
    rows[4] = '{15, 1, 0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1},  36, 15, 15, 15, 1, 0, 4, 91, 0};
    rows[5] = '{2, 0, 0, {8'd0, 8'd0, 8'd3, 8'd3},  {8'd0, 8'd0, 8'd3, 8'd3},   0, 1, 32, 0, 0, 1, -1, -1, 1};

    start = 1'b0; in_valid = 1'b0; vec_len = '0; da = '0; db = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_async_outputs", int'(outs), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_held_outputs", int'(outs), 0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", int'(outs), 0);

    for (int i = 0; i < 6; i++) begin
      run_job(i, rows[i]);
      $display("row %0d len=%0d lat=%0d sum=%0d checks=%0d failures=%0d",
               i, rows[i].len, rows[i].lat, acc, checks, failures);
    end

    // Operand withheld for 10 cycles in WAIT_OP
    cur_lat = 2; vec_len = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk); #1;
      if (in_ready) found = 1'b1;
    end
    chk("gap_reach_wait_op", int'(found), 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("gap_hold_c%0d", c), int'({in_ready, ldA, ldB, busy}), 4'b1001);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; da = 8'd6; db = 8'd7;
    @(negedge clk);
    chk("gap_handshake", int'({in_ready, ldA, ldB}), 3'b111);
    @(posedge clk); #1;
    @(negedge clk);
    chk("gap_in_valid_ignored", int'({in_ready, ldA, ldB}), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (done) found = 1'b1;
      @(posedge clk); #1;
    end
    chk("gap_done_seen", int'(found), 1);
    chk("gap_sum", acc, 42);
    $display("gap sequence sum=%0d checks=%0d failures=%0d", acc, checks, failures);

    // Restart while busy, then reset in MUL_RUN
    cur_lat = 0; in_valid = 1'b1; da = 8'd2; db = 8'd2;
    b_clr = n_clr; b_done = n_done; b_to = n_to;
    vec_len = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk); #1;
      if (start_mul) found = 1'b1;
    end
    chk("rst_reach_mul_run", int'(found), 1);
    start = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    chk("restart_ignored_mul_run", int'(start_mul), 1);
    chk("restart_ignored_clr", n_clr - b_clr, 1);
    #2 rst = 1'b0;
    #1;
    chk("midjob_reset_outputs", int'(outs), 0);
    chk("midjob_reset_busy", int'(busy), 0);
    repeat (2) begin
      @(negedge clk);
      chk("midjob_reset_held", int'(outs), 0);
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midjob_idle_after", int'(busy), 0);
    chk("midjob_no_done", n_done - b_done, 0);
    chk("midjob_no_timeout", n_to - b_to, 0);
    $display("reset sequence checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
